// File: rtl/cc_speedcounter.sv
// Period generator: counts TC = (8 - level) * base cycles per period and emits a
// one-cycle active-low tick plus a modulo-256 tick counter, with start/pause control.
`timescale 1ns/1ps

module cc_speedcounter #(
    parameter int unsigned                       SPEEDCOUNTER_DATAWIDTH = 23,
    parameter logic [SPEEDCOUNTER_DATAWIDTH-1:0] SPEEDCOUNTER_BASE      = 23'd8480
) (
    input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
    input  logic                              CC_SPEEDCOUNTER_RESET_InLow,
    input  logic                              CC_SPEEDCOUNTER_start_InLow,
    input  logic                              CC_SPEEDCOUNTER_pause_InHigh,
    input  logic [2:0]                        CC_SPEEDCOUNTER_level_InBUS,
    output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
    output logic                              CC_SPEEDCOUNTER_T0_OutLow,
    output logic [7:0]                        CC_SPEEDCOUNTER_step_OutBUS,
    output logic                              CC_SPEEDCOUNTER_running_OutHigh
);

    localparam int unsigned DW = SPEEDCOUNTER_DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } stateType;

    stateType       state;
    logic [2:0]     levelLatched;
    logic [3:0]     periodMult;
    logic [DW-1:0]  termCount;
    logic           atLast;

    // Terminal count follows the latched level, so mid-period level changes wait for the wrap
    always_comb begin
        periodMult = 4'd8 - {1'b0, levelLatched};
        termCount  = DW'(periodMult) * SPEEDCOUNTER_BASE;
    end

    assign atLast = (CC_SPEEDCOUNTER_data_OutBUS == (termCount - DW'(1)));

    // Start beats pause, pause beats wrap; PAUSE with pause released behaves exactly like RUN
    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
        if (!CC_SPEEDCOUNTER_RESET_InLow) begin
            state                           <= IDLE;
            levelLatched                    <= 3'd0;
            CC_SPEEDCOUNTER_data_OutBUS     <= '0;
            CC_SPEEDCOUNTER_step_OutBUS     <= 8'd0;
            CC_SPEEDCOUNTER_T0_OutLow       <= 1'b1;
            CC_SPEEDCOUNTER_running_OutHigh <= 1'b0;
        end else if (!CC_SPEEDCOUNTER_start_InLow) begin
            state                           <= RUN;
            levelLatched                    <= CC_SPEEDCOUNTER_level_InBUS;
            CC_SPEEDCOUNTER_data_OutBUS     <= '0;
            CC_SPEEDCOUNTER_step_OutBUS     <= 8'd0;
            CC_SPEEDCOUNTER_T0_OutLow       <= 1'b1;
            CC_SPEEDCOUNTER_running_OutHigh <= 1'b1;
        end else begin
            case (state)
                RUN, PAUSE: begin
                    if (CC_SPEEDCOUNTER_pause_InHigh) begin
                        state                           <= PAUSE;
                        CC_SPEEDCOUNTER_T0_OutLow       <= 1'b1;
                        CC_SPEEDCOUNTER_running_OutHigh <= 1'b0;
                    end else begin
                        state                           <= RUN;
                        CC_SPEEDCOUNTER_running_OutHigh <= 1'b1;
                        if (atLast) begin
                            levelLatched                <= CC_SPEEDCOUNTER_level_InBUS;
                            CC_SPEEDCOUNTER_data_OutBUS <= '0;
                            CC_SPEEDCOUNTER_step_OutBUS <= CC_SPEEDCOUNTER_step_OutBUS + 8'd1;
                            CC_SPEEDCOUNTER_T0_OutLow   <= 1'b0;
                        end else begin
                            CC_SPEEDCOUNTER_data_OutBUS <= CC_SPEEDCOUNTER_data_OutBUS + DW'(1);
                            CC_SPEEDCOUNTER_T0_OutLow   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state                           <= IDLE;
                    CC_SPEEDCOUNTER_data_OutBUS     <= '0;
                    CC_SPEEDCOUNTER_T0_OutLow       <= 1'b1;
                    CC_SPEEDCOUNTER_running_OutHigh <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_speedcounter.sv
// Directed bench for cc_speedcounter: one default-parameter instance for exact-period
// scenarios and one short-base instance for long multi-period scenarios.
`timescale 1ns/1ps

module tb_cc_speedcounter;

    logic        clk;
    logic        rstN;
    logic        startN;
    logic        pause;
    logic [2:0]  level;

    logic [22:0] dataD, dataS;
    logic        t0D, t0S;
    logic [7:0]  stepD, stepS;
    logic        runD, runS;

    int errors;
    int checks;

    cc_speedcounter dutD (
        .CC_SPEEDCOUNTER_CLOCK_50       (clk),
        .CC_SPEEDCOUNTER_RESET_InLow    (rstN),
        .CC_SPEEDCOUNTER_start_InLow    (startN),
        .CC_SPEEDCOUNTER_pause_InHigh   (pause),
        .CC_SPEEDCOUNTER_level_InBUS    (level),
        .CC_SPEEDCOUNTER_data_OutBUS    (dataD),
        .CC_SPEEDCOUNTER_T0_OutLow      (t0D),
        .CC_SPEEDCOUNTER_step_OutBUS    (stepD),
        .CC_SPEEDCOUNTER_running_OutHigh(runD)
    );

    // Base of 16 cycles: TC = 128 at L = 0, 16 at L = 7
    cc_speedcounter #(
        .SPEEDCOUNTER_DATAWIDTH(23),
        .SPEEDCOUNTER_BASE     (23'd16)
    ) dutS (
        .CC_SPEEDCOUNTER_CLOCK_50       (clk),
        .CC_SPEEDCOUNTER_RESET_InLow    (rstN),
        .CC_SPEEDCOUNTER_start_InLow    (startN),
        .CC_SPEEDCOUNTER_pause_InHigh   (pause),
        .CC_SPEEDCOUNTER_level_InBUS    (level),
        .CC_SPEEDCOUNTER_data_OutBUS    (dataS),
        .CC_SPEEDCOUNTER_T0_OutLow      (t0S),
        .CC_SPEEDCOUNTER_step_OutBUS    (stepS),
        .CC_SPEEDCOUNTER_running_OutHigh(runS)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return the bench sits in the cycle that begins at the start edge
    task automatic startPulse();
        startN = 1'b0;
        tick();
        startN = 1'b1;
    endtask

    // Runs n cycles and records position, data and step of the first two ticks
    task automatic watch(input bit sm, input int n, output int nT, output int p1, output int p2,
                         output logic [22:0] d1, output logic [22:0] d2,
                         output logic [7:0] s1, output logic [7:0] s2);
        nT = 0; p1 = -1; p2 = -1; d1 = '1; d2 = '1; s1 = 8'd0; s2 = 8'd0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if ((sm ? t0S : t0D) == 1'b0) begin
                nT++;
                if (nT == 1) begin
                    p1 = i; d1 = sm ? dataS : dataD; s1 = sm ? stepS : stepD;
                end else if (nT == 2) begin
                    p2 = i; d2 = sm ? dataS : dataD; s2 = sm ? stepS : stepD;
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rstN = 1'b0; startN = 1'b1; pause = 1'b0; level = 3'd0;
        repeat (3) tick();
        checks++; if (dataD !== 23'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", dataD); end
        checks++; if (stepD !== 8'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", stepD); end
        checks++; if (t0D !== 1'b1) begin errors++; $display("FAIL reset_t0: got %b expected 1", t0D); end
        checks++; if (runD !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", runD); end
        checks++; if (runS !== 1'b0) begin errors++; $display("FAIL reset_running_small: got %b expected 0", runS); end
        rstN = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dataD !== 23'd0 || stepD !== 8'd0 || t0D !== 1'b1 || runD !== 1'b0 ||
                dataS !== 23'd0 || t0S !== 1'b1 || runS !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold: got %0d non-idle cycles expected 0", bad); end
    endtask

    task automatic test_base_period();
        int nT, p1, p2;
        logic [22:0] d1, d2;
        logic [7:0] s1, s2;
        level = 3'd7;
        startPulse();
        checks++; if (runD !== 1'b1) begin errors++; $display("FAIL base_running: got %b expected 1", runD); end
        checks++; if (dataD !== 23'd0) begin errors++; $display("FAIL base_data0: got %0d expected 0", dataD); end
        watch(1'b0, 16970, nT, p1, p2, d1, d2, s1, s2);
        checks++; if (nT != 2) begin errors++; $display("FAIL base_ticks: got %0d expected 2", nT); end
        checks++; if (p1 != 8480) begin errors++; $display("FAIL base_pos1: got %0d expected 8480", p1); end
        checks++; if (p2 != 16960) begin errors++; $display("FAIL base_pos2: got %0d expected 16960", p2); end
        checks++; if (d1 !== 23'd0) begin errors++; $display("FAIL base_data1: got %0d expected 0", d1); end
        checks++; if (d2 !== 23'd0) begin errors++; $display("FAIL base_data2: got %0d expected 0", d2); end
        checks++; if (s1 !== 8'd1) begin errors++; $display("FAIL base_step1: got %0d expected 1", s1); end
        checks++; if (s2 !== 8'd2) begin errors++; $display("FAIL base_step2: got %0d expected 2", s2); end
    endtask

    task automatic test_level_change();
        int nT, p1, p2;
        logic [22:0] d1, d2;
        logic [7:0] s1, s2;
        level = 3'd0;
        startPulse();
        repeat (60) tick();
        checks++; if (dataS !== 23'd60) begin errors++; $display("FAIL lvl_count: got %0d expected 60", dataS); end
        level = 3'd7;
        watch(1'b1, 90, nT, p1, p2, d1, d2, s1, s2);
        checks++; if (nT != 2) begin errors++; $display("FAIL lvl_ticks: got %0d expected 2", nT); end
        checks++; if (p1 != 68) begin errors++; $display("FAIL lvl_pos1: got %0d expected 68", p1); end
        checks++; if (p2 != 84) begin errors++; $display("FAIL lvl_pos2: got %0d expected 84", p2); end
        checks++; if (d1 !== 23'd0) begin errors++; $display("FAIL lvl_data1: got %0d expected 0", d1); end
        checks++; if (s2 !== 8'd2) begin errors++; $display("FAIL lvl_step2: got %0d expected 2", s2); end
    endtask

    task automatic test_start_priority();
        level = 3'd7;
        pause = 1'b1;
        startN = 1'b0;
        tick();
        checks++; if (runS !== 1'b1) begin errors++; $display("FAIL prio_run: got %b expected 1", runS); end
        checks++; if (dataS !== 23'd0) begin errors++; $display("FAIL prio_data: got %0d expected 0", dataS); end
        startN = 1'b1;
        tick();
        checks++; if (runS !== 1'b0) begin errors++; $display("FAIL prio_paused: got %b expected 0", runS); end
        checks++; if (dataS !== 23'd0) begin errors++; $display("FAIL prio_held: got %0d expected 0", dataS); end
        pause = 1'b0;
        tick();
        checks++; if (runS !== 1'b1) begin errors++; $display("FAIL prio_resume_run: got %b expected 1", runS); end
        checks++; if (dataS !== 23'd1) begin errors++; $display("FAIL prio_resume_data: got %0d expected 1", dataS); end
    endtask

    task automatic test_pause();
        int bad, nT, p1, p2;
        logic [22:0] d1, d2;
        logic [7:0] s1, s2;
        level = 3'd7;
        startPulse();
        repeat (5000) tick();
        checks++; if (dataD !== 23'd5000) begin errors++; $display("FAIL pause_count: got %0d expected 5000", dataD); end
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dataD !== 23'd5000 || t0D !== 1'b1 || runD !== 1'b0 || stepD !== 8'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
        pause = 1'b0;
        watch(1'b0, 3490, nT, p1, p2, d1, d2, s1, s2);
        checks++; if (nT != 1) begin errors++; $display("FAIL pause_ticks: got %0d expected 1", nT); end
        checks++; if (p1 != 3480) begin errors++; $display("FAIL pause_pos: got %0d expected 3480", p1); end
        checks++; if (s1 !== 8'd1) begin errors++; $display("FAIL pause_step: got %0d expected 1", s1); end
    endtask

    task automatic test_pause_at_wrap();
        int bad;
        level = 3'd7;
        startPulse();
        repeat (8479) tick();
        checks++; if (dataD !== 23'd8479) begin errors++; $display("FAIL pwrap_count: got %0d expected 8479", dataD); end
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dataD !== 23'd8479 || t0D !== 1'b1 || stepD !== 8'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pwrap_hold: got %0d bad cycles expected 0", bad); end
        pause = 1'b0;
        tick();
        checks++; if (t0D !== 1'b0) begin errors++; $display("FAIL pwrap_t0: got %b expected 0", t0D); end
        checks++; if (dataD !== 23'd0) begin errors++; $display("FAIL pwrap_data: got %0d expected 0", dataD); end
        checks++; if (stepD !== 8'd1) begin errors++; $display("FAIL pwrap_step: got %0d expected 1", stepD); end
    endtask

    task automatic test_step_wrap();
        int nT, p256;
        logic [7:0] s255, s256;
        level = 3'd7;
        startPulse();
        nT = 0; p256 = -1; s255 = 8'd0; s256 = 8'hAA;
        for (int i = 1; i <= 4100; i++) begin
            tick();
            if (t0S == 1'b0) begin
                nT++;
                if (nT == 255) s255 = stepS;
                if (nT == 256) begin s256 = stepS; p256 = i; end
            end
        end
        checks++; if (nT != 256) begin errors++; $display("FAIL swrap_ticks: got %0d expected 256", nT); end
        checks++; if (p256 != 4096) begin errors++; $display("FAIL swrap_pos: got %0d expected 4096", p256); end
        checks++; if (s255 !== 8'd255) begin errors++; $display("FAIL swrap_step255: got %0d expected 255", s255); end
        checks++; if (s256 !== 8'd0) begin errors++; $display("FAIL swrap_step256: got %0d expected 0", s256); end
    endtask

    task automatic test_restart();
        int nT, p1, p2;
        logic [22:0] d1, d2;
        logic [7:0] s1, s2;
        level = 3'd7;
        startPulse();
        repeat (4000) tick();
        checks++; if (dataD !== 23'd4000) begin errors++; $display("FAIL rst_count: got %0d expected 4000", dataD); end
        checks++; if (stepS !== 8'd250) begin errors++; $display("FAIL rst_step_small: got %0d expected 250", stepS); end
        startPulse();
        checks++; if (dataD !== 23'd0) begin errors++; $display("FAIL restart_data: got %0d expected 0", dataD); end
        checks++; if (stepS !== 8'd0) begin errors++; $display("FAIL restart_step: got %0d expected 0", stepS); end
        checks++; if (dataS !== 23'd0) begin errors++; $display("FAIL restart_data_small: got %0d expected 0", dataS); end
        watch(1'b0, 8490, nT, p1, p2, d1, d2, s1, s2);
        checks++; if (nT != 1) begin errors++; $display("FAIL restart_ticks: got %0d expected 1", nT); end
        checks++; if (p1 != 8480) begin errors++; $display("FAIL restart_pos: got %0d expected 8480", p1); end
    endtask

    task automatic test_async_reset();
        int bad;
        level = 3'd7;
        startPulse();
        repeat (4000) tick();
        #4;
        rstN = 1'b0;
        #1;
        checks++; if (dataD !== 23'd0) begin errors++; $display("FAIL areset_data: got %0d expected 0", dataD); end
        checks++; if (stepS !== 8'd0) begin errors++; $display("FAIL areset_step: got %0d expected 0", stepS); end
        checks++; if (t0D !== 1'b1) begin errors++; $display("FAIL areset_t0: got %b expected 1", t0D); end
        checks++; if (runD !== 1'b0) begin errors++; $display("FAIL areset_running: got %b expected 0", runD); end
        tick();
        rstN = 1'b1;
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (t0D !== 1'b1 || runD !== 1'b0 || dataD !== 23'd0 || t0S !== 1'b1 || runS !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL areset_idle: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstN = 1'b0; startN = 1'b1; pause = 1'b0; level = 3'd0;
        test_reset();
        test_base_period();
        test_level_change();
        test_start_priority();
        test_pause();
        test_pause_at_wrap();
        test_step_wrap();
        test_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
